frame_render_sequencer: RTL and testbench
=========================================

Name: frame_render_sequencer

Overview:
- Frame-level controller for the render pipeline.
- Per frame: accepts an object count from the MCU interface, clears the framebuffer, issues one render_pipeline start per object, then requests a buffer swap aligned to vsync.
- Sits between the MCU command path, render_pipeline and the framebuffer write port.
- Replaces ad-hoc state logic in the FPGA top level.

Parameters:
- MAX_OBJECTS, 1024, maximum objects per frame.
- OBJWIDTH, $clog2(MAX_OBJECTS+1), width of object counts and indices.
- FB_SIZE, 19200, framebuffer entries (160x120).
- ADDRWIDTH, $clog2(FB_SIZE), framebuffer address width.
- DEPTHWIDTH, 12, depth word width.
- COLORWIDTH, 4, color word width.
- CLEAR_DEPTH, all ones, depth value written during clear.
- CLEAR_COLOR, 0, color value written during clear.

Ports:
- clk_100m  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- i_mcu_dv  in  1  frame descriptor valid (level).
- i_mcu_num_objects  in  OBJWIDTH  object count for the frame.
- o_mcu_ack  out  1  one-cycle pulse: descriptor latched.
- o_rp_start  out  1  one-cycle render_pipeline start pulse.
- i_rp_ready  in  1  render_pipeline idle/ready.
- i_rp_finished  in  1  one-cycle pulse: current object done.
- o_obj_index  out  OBJWIDTH  index of object being rendered.
- o_clr_we  out  1  framebuffer clear write enable.
- o_clr_addr  out  ADDRWIDTH  clear write address.
- o_clr_depth  out  DEPTHWIDTH  clear depth data (CLEAR_DEPTH).
- o_clr_color  out  COLORWIDTH  clear color data (CLEAR_COLOR).
- o_swap_req  out  1  buffer swap request, held high until vsync.
- i_vsync  in  1  one-cycle vsync pulse from display.
- o_frame_done  out  1  one-cycle pulse at end of frame.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rstn=0 at a clk_100m edge):
  - State returns to IDLE from any state, including mid-clear or mid-render.
  - All outputs are 0; counters are 0.
  - An in-flight i_rp_finished is discarded.
- States: IDLE, AWAIT_MCU, CLEAR_FB, START_OBJ, WAIT_OBJ, SWAP, DONE.
- IDLE -> AWAIT_MCU when i_rp_ready=1.
- AWAIT_MCU:
  - On i_mcu_dv=1: latch N = min(i_mcu_num_objects, MAX_OBJECTS), pulse o_mcu_ack for exactly one cycle, go to CLEAR_FB.
- CLEAR_FB:
  - o_clr_we=1 for exactly FB_SIZE consecutive cycles, o_clr_addr = 0..FB_SIZE-1.
  - On the cycle with address FB_SIZE-1: go to START_OBJ if N>0, else SWAP.
  - o_clr_we=0 in all other states.
- START_OBJ:
  - Wait for i_rp_ready=1, then pulse o_rp_start for one cycle and go to WAIT_OBJ.
  - o_obj_index = objects completed so far; valid from START_OBJ through WAIT_OBJ.
- WAIT_OBJ:
  - On i_rp_finished: increment completed count.
  - If count reaches N go to SWAP, else START_OBJ.
  - Minimum gap between successive o_rp_start pulses is 2 cycles.
- i_rp_finished outside WAIT_OBJ is ignored; the count does not change.
- SWAP:
  - o_swap_req=1.
  - On i_vsync=1: drop o_swap_req next cycle, go to DONE.
  - A vsync that occurred before entering SWAP does not satisfy the request.
- DONE: o_frame_done=1 for one cycle, go to IDLE.
- i_mcu_dv outside AWAIT_MCU is ignored; no ack is issued.
- Counters are OBJWIDTH bits and never wrap: N is bounded by MAX_OBJECTS.
- All outputs are registered; no combinational path from any input to any output.

Optional Feature:
- FRAME_SEQ_PERF_EN defined:
  - Adds output o_frame_cycles, 32 bits.
  - Counts cycles from the AWAIT_MCU->CLEAR_FB transition up to and including DONE.
  - Latched at DONE, held until the next DONE; saturates at 2^32-1; reset to 0.
- Undefined: port still present, driven constant 0; no counter logic is synthesised.

Test Plan (bench uses FB_SIZE=16, MAX_OBJECTS=8):
- Basic frame: ready=1, mcu_dv with N=3, rp_finished 5 cycles after each start, vsync 10 cycles after SWAP entry -> one ack pulse, 16 clr writes at addr 0..15, exactly 3 o_rp_start with o_obj_index 0,1,2, swap_req high until vsync, one o_frame_done.
- Zero objects: N=0 -> clear completes, no o_rp_start, direct to SWAP, frame_done after vsync.
- Clamp and spurious inputs: N=12 -> exactly 8 starts. Extra rp_finished during CLEAR_FB and SWAP -> count unchanged. mcu_dv during render -> no ack.
- Backpressure: i_rp_ready=0 for 7 cycles in START_OBJ -> o_rp_start withheld, then a single pulse when ready rises.
- Reset mid-operation: rstn=0 at clear address 9, later with N=4 at object 2 -> all outputs 0 next cycle, state IDLE; next frame runs cleanly from addr 0 / index 0.
- With FRAME_SEQ_PERF_EN: N=2, rp_finished latency 3, vsync on first SWAP cycle -> o_frame_cycles equals the cycle count measured by the bench from ack to frame_done inclusive.

Source files
------------

// File: rtl/frame_render_sequencer.sv
// frame_render_sequencer
//
// Frame-level controller for the render pipeline. For each frame it latches an
// object count from the MCU, clears the framebuffer, starts render_pipeline
// once per object, then holds a buffer swap request until the next vsync.
//
// Ports:
//   clk_100m           system clock
//   rstn               synchronous active-low reset
//   i_mcu_dv           frame descriptor valid (level)
//   i_mcu_num_objects  object count for the frame (clamped to MAX_OBJECTS)
//   o_mcu_ack          one-cycle pulse: descriptor latched
//   o_rp_start         one-cycle render_pipeline start pulse
//   i_rp_ready         render_pipeline idle/ready
//   i_rp_finished      one-cycle pulse: current object done
//   o_obj_index        index of the object being rendered
//   o_clr_we           framebuffer clear write enable
//   o_clr_addr         clear write address
//   o_clr_depth        clear depth data
//   o_clr_color        clear color data
//   o_swap_req         buffer swap request, held until vsync
//   i_vsync            one-cycle vsync pulse from display
//   o_frame_done       one-cycle pulse at end of frame
//   o_busy             high in every state except idle
//   o_frame_cycles     frame cycle count (FRAME_SEQ_PERF_EN), else constant 0
//
// Build option: define FRAME_SEQ_PERF_EN to enable the frame cycle counter.
// All outputs are registered.

module frame_render_sequencer #(
    parameter int unsigned MAX_OBJECTS = 1024,
    parameter int unsigned OBJWIDTH    = $clog2(MAX_OBJECTS + 1),
    parameter int unsigned FB_SIZE     = 19200,
    parameter int unsigned ADDRWIDTH   = $clog2(FB_SIZE),
    parameter int unsigned DEPTHWIDTH  = 12,
    parameter int unsigned COLORWIDTH  = 4,
    parameter logic [DEPTHWIDTH-1:0] CLEAR_DEPTH = '1,
    parameter logic [COLORWIDTH-1:0] CLEAR_COLOR = '0
) (
    input  logic                  clk_100m,
    input  logic                  rstn,
    input  logic                  i_mcu_dv,
    input  logic [OBJWIDTH-1:0]   i_mcu_num_objects,
    output logic                  o_mcu_ack,
    output logic                  o_rp_start,
    input  logic                  i_rp_ready,
    input  logic                  i_rp_finished,
    output logic [OBJWIDTH-1:0]   o_obj_index,
    output logic                  o_clr_we,
    output logic [ADDRWIDTH-1:0]  o_clr_addr,
    output logic [DEPTHWIDTH-1:0] o_clr_depth,
    output logic [COLORWIDTH-1:0] o_clr_color,
    output logic                  o_swap_req,
    input  logic                  i_vsync,
    output logic                  o_frame_done,
    output logic                  o_busy,
    output logic [31:0]           o_frame_cycles
);

    typedef enum logic [2:0] {
        StIdle,
        StAwaitMcu,
        StClearFb,
        StStartObj,
        StWaitObj,
        StSwap,
        StDone
    } state_e;

    localparam logic [OBJWIDTH-1:0]  MaxObj   = OBJWIDTH'(MAX_OBJECTS);
    localparam logic [ADDRWIDTH-1:0] LastAddr = ADDRWIDTH'(FB_SIZE - 1);

    state_e                  state_q;
    logic [OBJWIDTH-1:0]     num_obj_q;
    logic [OBJWIDTH-1:0]     done_cnt_q;
    logic                    mcu_ack_q;
    logic                    rp_start_q;
    logic                    clr_we_q;
    logic [ADDRWIDTH-1:0]    clr_addr_q;
    logic [DEPTHWIDTH-1:0]   clr_depth_q;
    logic [COLORWIDTH-1:0]   clr_color_q;
    logic                    swap_req_q;
    logic                    frame_done_q;
    logic                    busy_q;

    logic [OBJWIDTH-1:0]     num_clamped;
    logic [OBJWIDTH-1:0]     cnt_inc;

    always_comb begin
        num_clamped = (i_mcu_num_objects > MaxObj) ? MaxObj : i_mcu_num_objects;
        cnt_inc     = done_cnt_q + OBJWIDTH'(1);
    end

    always_ff @(posedge clk_100m) begin
        if (!rstn) begin
            state_q      <= StIdle;
            num_obj_q    <= '0;
            done_cnt_q   <= '0;
            mcu_ack_q    <= 1'b0;
            rp_start_q   <= 1'b0;
            clr_we_q     <= 1'b0;
            clr_addr_q   <= '0;
            clr_depth_q  <= '0;
            clr_color_q  <= '0;
            swap_req_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // Pulse outputs default low; the transitions below raise them for one cycle.
            mcu_ack_q    <= 1'b0;
            rp_start_q   <= 1'b0;
            frame_done_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (i_rp_ready) begin
                        state_q <= StAwaitMcu;
                        busy_q  <= 1'b1;
                    end
                end

                StAwaitMcu: begin
                    if (i_mcu_dv) begin
                        num_obj_q   <= num_clamped;
                        done_cnt_q  <= '0;
                        mcu_ack_q   <= 1'b1;
                        clr_we_q    <= 1'b1;
                        clr_addr_q  <= '0;
                        clr_depth_q <= CLEAR_DEPTH;
                        clr_color_q <= CLEAR_COLOR;
                        state_q     <= StClearFb;
                    end
                end

                StClearFb: begin
                    if (clr_addr_q == LastAddr) begin
                        clr_we_q    <= 1'b0;
                        clr_addr_q  <= '0;
                        clr_depth_q <= '0;
                        clr_color_q <= '0;
                        if (num_obj_q != '0) begin
                            state_q <= StStartObj;
                        end else begin
                            state_q    <= StSwap;
                            swap_req_q <= 1'b1;
                        end
                    end else begin
                        clr_addr_q <= clr_addr_q + ADDRWIDTH'(1);
                    end
                end

                StStartObj: begin
                    if (i_rp_ready) begin
                        rp_start_q <= 1'b1;
                        state_q    <= StWaitObj;
                    end
                end

                StWaitObj: begin
                    if (i_rp_finished) begin
                        done_cnt_q <= cnt_inc;
                        if (cnt_inc == num_obj_q) begin
                            state_q    <= StSwap;
                            swap_req_q <= 1'b1;
                        end else begin
                            state_q <= StStartObj;
                        end
                    end
                end

                // Only vsync sampled while already in this state counts.
                StSwap: begin
                    if (i_vsync) begin
                        swap_req_q   <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= StDone;
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_mcu_ack    = mcu_ack_q;
    assign o_rp_start   = rp_start_q;
    assign o_obj_index  = done_cnt_q;
    assign o_clr_we     = clr_we_q;
    assign o_clr_addr   = clr_addr_q;
    assign o_clr_depth  = clr_depth_q;
    assign o_clr_color  = clr_color_q;
    assign o_swap_req   = swap_req_q;
    assign o_frame_done = frame_done_q;
    assign o_busy       = busy_q;

`ifdef FRAME_SEQ_PERF_EN
    // cyc_q holds the number of frame cycles up to and including the current one.
    logic [31:0] cyc_q;
    logic [31:0] frame_cycles_q;
    logic [31:0] cyc_inc;

    always_comb begin
        cyc_inc = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
    end

    always_ff @(posedge clk_100m) begin
        if (!rstn) begin
            cyc_q          <= '0;
            frame_cycles_q <= '0;
        end else begin
            if (state_q == StAwaitMcu && i_mcu_dv) begin
                cyc_q <= 32'd1;
            end else if (state_q == StClearFb || state_q == StStartObj ||
                         state_q == StWaitObj || state_q == StSwap) begin
                cyc_q <= cyc_inc;
            end
            // cyc_inc here already counts the upcoming done cycle.
            if (state_q == StSwap && i_vsync) begin
                frame_cycles_q <= cyc_inc;
            end
        end
    end

    assign o_frame_cycles = frame_cycles_q;
`else
    assign o_frame_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_frame_render_sequencer.sv
// Self-checking bench for frame_render_sequencer (FB_SIZE=16, MAX_OBJECTS=8).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_frame_render_sequencer;

    localparam int OW = 4;
    localparam int AW = 4;

    logic        clk_100m = 1'b0;
    logic        rstn;
    logic        i_mcu_dv;
    logic [OW-1:0] i_mcu_num_objects;
    logic        o_mcu_ack;
    logic        o_rp_start;
    logic        i_rp_ready;
    logic        i_rp_finished;
    logic [OW-1:0] o_obj_index;
    logic        o_clr_we;
    logic [AW-1:0] o_clr_addr;
    logic [11:0] o_clr_depth;
    logic [3:0]  o_clr_color;
    logic        o_swap_req;
    logic        i_vsync;
    logic        o_frame_done;
    logic        o_busy;
    logic [31:0] o_frame_cycles;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_100m = ~clk_100m;

    frame_render_sequencer #(
        .MAX_OBJECTS (8),
        .OBJWIDTH    (OW),
        .FB_SIZE     (16),
        .ADDRWIDTH   (AW)
    ) dut (
        .clk_100m          (clk_100m),
        .rstn              (rstn),
        .i_mcu_dv          (i_mcu_dv),
        .i_mcu_num_objects (i_mcu_num_objects),
        .o_mcu_ack         (o_mcu_ack),
        .o_rp_start        (o_rp_start),
        .i_rp_ready        (i_rp_ready),
        .i_rp_finished     (i_rp_finished),
        .o_obj_index       (o_obj_index),
        .o_clr_we          (o_clr_we),
        .o_clr_addr        (o_clr_addr),
        .o_clr_depth       (o_clr_depth),
        .o_clr_color       (o_clr_color),
        .o_swap_req        (o_swap_req),
        .i_vsync           (i_vsync),
        .o_frame_done      (o_frame_done),
        .o_busy            (o_busy),
        .o_frame_cycles    (o_frame_cycles)
    );

    typedef struct {
        int num;         // requested object count
        int lat;         // cycles from start to rp_finished
        int vd;          // cycles from swap entry to vsync
        int stall;       // cycles ready held low in START_OBJ after first object
        bit spur;        // spurious finished/vsync/dv during the frame
        int exp_starts;
    } frame_vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic longint all_outputs();
        return longint'({o_mcu_ack, o_rp_start, o_obj_index, o_clr_we, o_clr_addr,
                         o_clr_depth, o_clr_color, o_swap_req, o_frame_done, o_busy,
                         o_frame_cycles});
    endfunction

    task automatic run_frame(input int row, input frame_vec_t v);
        int cyc = 0;
        int acks = 0, clr_n = 0, clr_bad = 0, starts = 0, idx_bad = 0, gap_bad = 0;
        int swap_hi = 0, dones = 0, ack_cyc = 0, done_cyc = 0;
        int last_start = -100, fin_at = -1, vsync_at = -1, first_fin = -1, stall_gap = -1;
        bit in_swap = 0, busy_at_done = 0, swap_at_done = 1;
        i_mcu_num_objects = OW'(v.num);
        i_mcu_dv = 1'b1;
        i_rp_ready = 1'b1;
        while (dones == 0 && cyc < 600) begin
            @(negedge clk_100m);
            cyc++;
            if (o_mcu_ack) begin
                acks++;
                ack_cyc = cyc;
                if (!v.spur) i_mcu_dv = 1'b0;
            end
            if (o_clr_we) begin
                if (o_clr_addr != AW'(clr_n) || o_clr_depth != 12'hFFF || o_clr_color != 4'h0)
                    clr_bad++;
                clr_n++;
            end
            if (o_rp_start) begin
                if (o_obj_index != OW'(starts)) idx_bad++;
                if (cyc - last_start < 2) gap_bad++;
                if (starts == 1 && first_fin >= 0) stall_gap = cyc - first_fin;
                last_start = cyc;
                starts++;
                fin_at = cyc + v.lat;
            end
            if (o_swap_req) begin
                swap_hi++;
                if (!in_swap) begin
                    in_swap = 1'b1;
                    vsync_at = cyc + v.vd;
                end
            end
            if (o_frame_done) begin
                dones++;
                done_cyc = cyc;
                busy_at_done = o_busy;
                swap_at_done = o_swap_req;
            end
            i_rp_finished = (cyc == fin_at);
            if (cyc == fin_at && starts == 1 && first_fin < 0) first_fin = cyc;
            i_rp_ready = !(first_fin >= 0 && cyc > first_fin && cyc <= first_fin + v.stall);
            i_vsync = (cyc == vsync_at);
            if (v.spur) begin
                if (o_clr_we && (clr_n % 3 == 1)) i_rp_finished = 1'b1;
                if (o_swap_req && cyc != vsync_at) i_rp_finished = 1'b1;
                // vsync on the last clear cycle precedes swap entry and must be ignored
                if (o_clr_we && o_clr_addr == AW'(15)) i_vsync = 1'b1;
            end
        end
        i_rp_finished = 1'b0;
        i_vsync = 1'b0;
        i_mcu_dv = 1'b0;
        i_rp_ready = 1'b1;
        @(negedge clk_100m);
        check($sformatf("row%0d_ack_count", row), acks, 1);
        check($sformatf("row%0d_clr_writes", row), clr_n, 16);
        check($sformatf("row%0d_clr_bad_data", row), clr_bad, 0);
        check($sformatf("row%0d_starts", row), starts, v.exp_starts);
        check($sformatf("row%0d_obj_index_bad", row), idx_bad, 0);
        check($sformatf("row%0d_start_gap_bad", row), gap_bad, 0);
        check($sformatf("row%0d_swap_cycles", row), swap_hi, v.vd + 1);
        check($sformatf("row%0d_frame_done", row), dones, 1);
        check($sformatf("row%0d_busy_at_done", row), busy_at_done, 1);
        check($sformatf("row%0d_swap_at_done", row), swap_at_done, 0);
        check($sformatf("row%0d_busy_idle", row), o_busy, 0);
        if (v.num >= 2)
            check($sformatf("row%0d_stall_gap", row), stall_gap,
                  (v.stall > 0) ? v.stall + 2 : 2);
`ifdef FRAME_SEQ_PERF_EN
        check($sformatf("row%0d_frame_cycles", row), o_frame_cycles, done_cyc - ack_cyc + 1);
`else
        check($sformatf("row%0d_frame_cycles", row), o_frame_cycles, 0);
`endif
    endtask

    // mode 0: reset at clear address 9; mode 1: reset when object 2 starts (N=4)
    task automatic reset_mid(input int mode);
        int cyc = 0, fin_at = -1;
        bit hit = 0;
        i_mcu_num_objects = (mode == 0) ? OW'(3) : OW'(4);
        i_mcu_dv = 1'b1;
        i_rp_ready = 1'b1;
        while (!hit && cyc < 300) begin
            @(negedge clk_100m);
            cyc++;
            if (o_mcu_ack) i_mcu_dv = 1'b0;
            if (o_rp_start) fin_at = cyc + 2;
            i_rp_finished = (cyc == fin_at);
            if (mode == 0 && o_clr_we && o_clr_addr == AW'(9)) hit = 1'b1;
            if (mode == 1 && o_rp_start && o_obj_index == OW'(2)) hit = 1'b1;
        end
        check($sformatf("reset%0d_trigger_seen", mode), hit, 1);
        rstn = 1'b0;
        i_mcu_dv = 1'b0;
        i_rp_finished = 1'b1;  // in flight at reset, must be dropped
        @(negedge clk_100m);
        check($sformatf("reset%0d_outputs_zero", mode), all_outputs(), 0);
        i_rp_finished = 1'b0;
        @(negedge clk_100m);
        check($sformatf("reset%0d_held_zero", mode), all_outputs(), 0);
        rstn = 1'b1;
    endtask

    frame_vec_t vecs[6];
    frame_vec_t rv;

    initial begin
        vecs[0] = '{num: 3,  lat: 5, vd: 10, stall: 0, spur: 1'b0, exp_starts: 3};
        vecs[1] = '{num: 0,  lat: 5, vd: 4,  stall: 0, spur: 1'b1, exp_starts: 0};
        vecs[2] = '{num: 12, lat: 2, vd: 3,  stall: 0, spur: 1'b1, exp_starts: 8};
        vecs[3] = '{num: 2,  lat: 4, vd: 1,  stall: 7, spur: 1'b0, exp_starts: 2};
        vecs[4] = '{num: 1,  lat: 0, vd: 0,  stall: 0, spur: 1'b0, exp_starts: 1};
        vecs[5] = '{num: 2,  lat: 3, vd: 0,  stall: 0, spur: 1'b0, exp_starts: 2};

        rstn = 1'b0;
        i_mcu_dv = 1'b0;
        i_mcu_num_objects = '0;
        i_rp_ready = 1'b0;
        i_rp_finished = 1'b0;
        i_vsync = 1'b0;
        repeat (3) @(negedge clk_100m);
        check("reset_outputs", all_outputs(), 0);
        rstn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_frame(i, vecs[i]);
        end

        reset_mid(0);
        run_frame(10, vecs[0]);
        reset_mid(1);
        rv = '{num: 4, lat: 2, vd: 2, stall: 0, spur: 1'b0, exp_starts: 4};
        run_frame(11, rv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
